soc_system_pio_master: RTL and testbench
========================================

# soc_system_pio_master

Avalon-MM initiator that turns single-beat commands from fabric logic into read or write transfers on a PIO-style slave port. Slaves on this port are the `soc_system_pio_*` registers. The block sits on the FPGA-side fabric so RTL controllers can program PIO registers, such as the VGA write-enable, without HPS involvement. It handles slave stalls via `waitrequest`, a fixed read latency, and a stall timeout that reports an error response.

## Interface
Parameters:
- ADDR_W, 2, Avalon address width (word address)
- DATA_W, 32, data width
- READ_LATENCY, 1, cycles from read acceptance to valid `readdata`; legal range 0–3
- TIMEOUT, 255, consecutive `waitrequest` cycles before abort; legal range 1–65535

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when `cmd_valid & cmd_ready`
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  ADDR_W  target word address
- cmd_writedata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_readdata  out  DATA_W  read data; 0 for writes and errors
- rsp_error  out  1  timeout flag, qualified by `rsp_valid`
- address  out  ADDR_W  Avalon address
- chipselect  out  1  Avalon select
- write_n  out  1  Avalon write strobe, active-low
- read_n  out  1  Avalon read strobe, active-low
- writedata  out  DATA_W  Avalon write data
- readdata  in  DATA_W  Avalon read data
- waitrequest  in  1  slave stall; tie to 0 for slaves without stall

## Operation
- States: IDLE, ISSUE, RDWAIT, RESP.
- **IDLE**
  - `cmd_ready` = 1.
  - On handshake: register `cmd_address`, `cmd_writedata` and `cmd_write`; clear the timeout counter; go to ISSUE.
- **ISSUE**
  - Outputs: `chipselect` = 1, `address` and `writedata` from the registers, and `write_n` = 0 (write) or `read_n` = 0 (read).
  - Completion: the transfer completes at the edge where `waitrequest` = 0.
    - Write completes → RESP.
    - Read completes with READ_LATENCY = 0 → capture `readdata` on that edge, go to RESP.
    - Read completes with READ_LATENCY > 0 → go to RDWAIT.
  - Stall: each cycle with `waitrequest` = 1 increments the counter. On reaching TIMEOUT: drop strobes, set the error flag, go to RESP.
- **RDWAIT**
  - Strobes and `chipselect` deasserted.
  - Count READ_LATENCY cycles, capture `readdata` on the last, go to RESP.
- **RESP**
  - `rsp_valid` = 1 for exactly one cycle, then IDLE.
  - There is no response backpressure; the consumer must accept the pulse.
- `rsp_readdata` and `rsp_error` hold their value until the next RESP.
- `rsp_readdata` is forced to 0 on writes and on errors.
- `cmd_ready` = 0 in every state except IDLE; only one transaction is outstanding.
- Commands presented while `cmd_ready` = 0 are ignored; the source holds them.
- The timeout counter is sized `$clog2(TIMEOUT+1)` bits and never wraps; it saturates at TIMEOUT.

## Timing
- Reset values:
  - `cmd_ready` = 1, `rsp_valid` = 0, `rsp_error` = 0, `rsp_readdata` = 0.
  - `chipselect` = 0, `write_n` = 1, `read_n` = 1, `address` = 0, `writedata` = 0.
  - State = IDLE.
- Reset mid-transaction:
  - Strobes deassert immediately, without waiting for a clock.
  - The transaction is discarded; no response is produced.
- Write with no stall: accept at edge 0, strobe visible in cycle 1, `rsp_valid` in cycle 2, `cmd_ready` high in cycle 3. Sustained rate is one command per 3 cycles.
- Read adds READ_LATENCY cycles to the write case.
- Each stall cycle adds one cycle.
- Timeout: exactly TIMEOUT strobe cycles, then RESP with `rsp_error` = 1.
  - If `waitrequest` falls on the TIMEOUT-th cycle, completion wins and no error is flagged.
- All outputs are registered.
- `readdata` is sampled only at the capture edge defined above; at other times it is don't-care.

## Test plan
- Reset, then write: `cmd_write` = 1, address 0, data 0x1, `waitrequest` = 0 → one-cycle `write_n` = 0 and `chipselect` = 1 with address 0, data 0x1; `rsp_valid` 2 cycles after accept with `rsp_error` = 0 and `rsp_readdata` = 0; a slave PIO model reads back 0x1.
- Read with READ_LATENCY = 1 from a model returning 0xA5A5_0001 one cycle after the strobe → `rsp_readdata` = 0xA5A5_0001; `rsp_valid` at cycle 3 after accept.
- Stalled write with `waitrequest` high for 4 cycles → strobe held 5 cycles, address and data stable throughout, then response with `rsp_error` = 0.
- TIMEOUT = 8 with `waitrequest` stuck high → strobes drop after 8 cycles; `rsp_valid` and `rsp_error` = 1; `rsp_readdata` = 0; next command accepted normally.
- Back-to-back: `cmd_valid` held high with 3 writes (0x1, 0x0, 0x1) → accepted every 3 cycles, `cmd_ready` low between accepts, strobes in order.
- Assert `reset` while a read strobe is active → `read_n` = 1 and `chipselect` = 0 before the next clock edge; no `rsp_valid`; `cmd_ready` = 1 after release.

Source files
------------

// File: rtl/soc_system_pio_master.sv
// Avalon-MM single-beat initiator for soc_system_pio_* slaves.
// Accepts one fabric command at a time and returns a one-cycle response, with stall timeout.
module soc_system_pio_master #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write_n,
  output logic              read_n,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest
);

  localparam int CNT_W      = $clog2(TIMEOUT + 1);
  localparam int LAT_LAST_I = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

  localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       LAT_LAST = 2'(LAT_LAST_I);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    tmo_cnt_r, tmo_cnt_s;
  logic [1:0]          lat_cnt_r, lat_cnt_s;
  logic                wr_r, wr_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;
  logic                cs_r, cs_s;
  logic                write_n_r, write_n_s;
  logic                read_n_r, read_n_s;
  logic                cmd_ready_r, cmd_ready_s;
  logic                rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_s;
  logic                rsp_err_r, rsp_err_s;

  assign cmd_ready    = cmd_ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_readdata = rsp_rdata_r;
  assign rsp_error    = rsp_err_r;
  assign address      = addr_r;
  assign chipselect   = cs_r;
  assign write_n      = write_n_r;
  assign read_n       = read_n_r;
  assign writedata    = wdata_r;

  // Next-state and next-output logic; strobes default low-active idle, response fields hold.
  always_comb begin
    state_s     = state_r;
    tmo_cnt_s   = tmo_cnt_r;
    lat_cnt_s   = lat_cnt_r;
    wr_s        = wr_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    cs_s        = 1'b0;
    write_n_s   = 1'b1;
    read_n_s    = 1'b1;
    cmd_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = rsp_rdata_r;
    rsp_err_s   = rsp_err_r;

    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          wr_s      = cmd_write;
          addr_s    = cmd_address;
          wdata_s   = cmd_writedata;
          tmo_cnt_s = '0;
          cs_s      = 1'b1;
          write_n_s = ~cmd_write;
          read_n_s  = cmd_write;
          state_s   = ISSUE;
        end else begin
          cmd_ready_s = 1'b1;
        end
      end

      ISSUE: begin
        if (!waitrequest) begin
          if (wr_r) begin
            rsp_valid_s = 1'b1;
            rsp_rdata_s = '0;
            rsp_err_s   = 1'b0;
            state_s     = RESP;
          end else if (READ_LATENCY == 0) begin
            rsp_valid_s = 1'b1;
            rsp_rdata_s = readdata;
            rsp_err_s   = 1'b0;
            state_s     = RESP;
          end else begin
            lat_cnt_s = 2'd0;
            state_s   = RDWAIT;
          end
        end else if (tmo_cnt_r >= TO_LAST) begin
          // Stall budget exhausted: abandon the transfer and report an error.
          tmo_cnt_s   = TO_MAX;
          rsp_valid_s = 1'b1;
          rsp_rdata_s = '0;
          rsp_err_s   = 1'b1;
          state_s     = RESP;
        end else begin
          tmo_cnt_s = tmo_cnt_r + CNT_W'(1);
          cs_s      = 1'b1;
          write_n_s = ~wr_r;
          read_n_s  = wr_r;
        end
      end

      RDWAIT: begin
        if (lat_cnt_r == LAT_LAST) begin
          rsp_valid_s = 1'b1;
          rsp_rdata_s = readdata;
          rsp_err_s   = 1'b0;
          state_s     = RESP;
        end else begin
          lat_cnt_s = lat_cnt_r + 2'd1;
        end
      end

      RESP: begin
        cmd_ready_s = 1'b1;
        state_s     = IDLE;
      end

      default: begin
        cmd_ready_s = 1'b1;
        state_s     = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears strobes asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      tmo_cnt_r   <= '0;
      lat_cnt_r   <= 2'd0;
      wr_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      cs_r        <= 1'b0;
      write_n_r   <= 1'b1;
      read_n_r    <= 1'b1;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      tmo_cnt_r   <= tmo_cnt_s;
      lat_cnt_r   <= lat_cnt_s;
      wr_r        <= wr_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      cs_r        <= cs_s;
      write_n_r   <= write_n_s;
      read_n_r    <= read_n_s;
      cmd_ready_r <= cmd_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

endmodule

// File: tb/tb_soc_system_pio_master.sv
// Directed bench for soc_system_pio_master with a 4-word PIO slave model (READ_LATENCY=1, TIMEOUT=8).
module tb_soc_system_pio_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_address = 2'd0;
  logic [31:0] cmd_writedata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_readdata;
  logic        rsp_error;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest = 1'b0;

  logic [31:0] mem [0:3];
  logic [31:0] rd_pipe = 32'hDEAD_BEEF;
  int n_cmp = 0;
  int n_err = 0;

  soc_system_pio_master #(
    .ADDR_W(2), .DATA_W(32), .READ_LATENCY(1), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
    .address(address), .chipselect(chipselect), .write_n(write_n), .read_n(read_n),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  // PIO slave: writes on accepted strobe; read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (chipselect && !write_n && !waitrequest) mem[address] <= writedata;
    if (chipselect && !read_n && !waitrequest) rd_pipe <= mem[address];
    else rd_pipe <= 32'hDEAD_BEEF;
  end
  assign readdata = rd_pipe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Present a command at a negedge, wait for the handshake, return at the strobe cycle.
  task automatic send(input logic w, input logic [1:0] a, input logic [31:0] d);
    int g;
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_writedata = d;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) check("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [31:0] bb_data [0:2];
    bb_data[0] = 32'h1; bb_data[1] = 32'h0; bb_data[2] = 32'h1;

    // Reset values
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp", {29'd0, rsp_valid, rsp_error, |rsp_readdata}, 32'd0);
    check("rst_strobes", {29'd0, chipselect, write_n, read_n}, 32'b011);
    check("rst_addr_data", {30'd0, address} | writedata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Simple write, no stall
    send(1'b1, 2'd0, 32'h1);
    check("wr_strobe", {29'd0, chipselect, write_n, read_n}, 32'b101);
    check("wr_addr", {30'd0, address}, 32'd0);
    check("wr_data", writedata, 32'h1);
    check("wr_c1_ready_valid", {30'd0, cmd_ready, rsp_valid}, 32'b00);
    @(negedge clk);
    check("wr_c2_rsp", {29'd0, rsp_valid, rsp_error, cmd_ready}, 32'b100);
    check("wr_c2_rdata", rsp_readdata, 32'd0);
    check("wr_c2_strobe", {29'd0, chipselect, write_n, read_n}, 32'b011);
    @(negedge clk);
    check("wr_c3", {30'd0, cmd_ready, rsp_valid}, 32'b10);
    check("wr_mem0", mem[0], 32'h1);

    // Stalled write: waitrequest high for 4 cycles
    waitrequest = 1'b1;
    send(1'b1, 2'd1, 32'h0000_005A);
    cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) waitrequest = 1'b0;
      if (chipselect && !write_n && address == 2'd1 && writedata == 32'h5A && !rsp_valid) cnt++;
      @(negedge clk);
    end
    check("stall_strobe_cycles", cnt, 32'd5);
    check("stall_rsp", {29'd0, rsp_valid, rsp_error, write_n}, 32'b101);
    @(negedge clk);
    check("stall_mem1", mem[1], 32'h5A);

    // Read with latency 1
    send(1'b1, 2'd2, 32'hA5A5_0001);
    @(negedge clk);
    @(negedge clk);
    send(1'b0, 2'd2, 32'h0);
    check("rd_strobe", {29'd0, chipselect, write_n, read_n}, 32'b110);
    check("rd_addr", {30'd0, address}, 32'd2);
    @(negedge clk);
    check("rd_c2", {28'd0, chipselect, read_n, rsp_valid, cmd_ready}, 32'b0100);
    @(negedge clk);
    check("rd_c3_rsp", {30'd0, rsp_valid, rsp_error}, 32'b10);
    check("rd_c3_rdata", rsp_readdata, 32'hA5A5_0001);
    @(negedge clk);
    check("rd_hold_rdata", rsp_readdata, 32'hA5A5_0001);

    // Timeout: waitrequest stuck high
    waitrequest = 1'b1;
    send(1'b0, 2'd3, 32'h0);
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      if (chipselect && !read_n && !rsp_valid) cnt++;
      @(negedge clk);
    end
    check("tmo_strobe_cycles", cnt, 32'd8);
    check("tmo_rsp", {28'd0, chipselect, read_n, rsp_valid, rsp_error}, 32'b0111);
    check("tmo_rdata", rsp_readdata, 32'd0);
    waitrequest = 1'b0;
    @(negedge clk);
    check("tmo_ready_after", {31'd0, cmd_ready}, 32'd1);

    // Completion on the 8th stall-window cycle wins over timeout
    waitrequest = 1'b1;
    send(1'b1, 2'd3, 32'h0000_0077);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) waitrequest = 1'b0;
      @(negedge clk);
    end
    check("tmo_edge_rsp", {30'd0, rsp_valid, rsp_error}, 32'b10);
    @(negedge clk);
    check("tmo_edge_mem3", mem[3], 32'h77);

    // Back-to-back writes with cmd_valid held high
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd0; cmd_writedata = bb_data[0];
    for (int k = 0; k < 3; k++) begin
      check("bb_ready_before", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      check("bb_strobe", {28'd0, cmd_ready, chipselect, write_n, read_n}, 32'b0101);
      check("bb_data", writedata, bb_data[k]);
      if (k < 2) cmd_writedata = bb_data[k + 1];
      else cmd_valid = 1'b0;
      @(negedge clk);
      check("bb_rsp", {30'd0, cmd_ready, rsp_valid}, 32'b01);
      @(negedge clk);
    end
    check("bb_mem0", mem[0], 32'h1);

    // Reset during an active read strobe
    waitrequest = 1'b1;
    send(1'b0, 2'd2, 32'h0);
    check("rr_strobe_on", {30'd0, chipselect, read_n}, 32'b10);
    #2 reset = 1'b1;
    #1;
    check("rr_async_strobe", {29'd0, chipselect, read_n, cmd_ready}, 32'b011);
    @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) cnt++;
      @(negedge clk);
    end
    check("rr_no_rsp", cnt, 32'd0);
    check("rr_ready", {31'd0, cmd_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
